// File: rtl/imem_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_pkg
// Purpose  : Shared types and constants for the instruction-memory boot
//            controller (state encoding, NOP instruction, default depth).
// Revision : 1.0 - initial release
// ============================================================================
package imem_boot_pkg;

  // Boot/run phase of the instruction memory
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } boot_state_t;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH = 1024;

endpackage : imem_boot_pkg
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_ctrl
// Purpose  : Sequences a single-port instruction memory: zero-clear after
//            reset, load a program from a valid/ready word stream, then hand
//            the read port to the core fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 10
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [31:0]       core_pc,
  output logic [31:0]       instruction,
  output logic              core_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow,
  output logic              err_misalign
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_PTR  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  boot_state_t       state;
  boot_state_t       next_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W:0]   wr_ptr;
  logic              xfer;

  // Upper PC bits beyond the memory are dropped (address wraps by truncation)
  logic unused_pc_bits;
  assign unused_pc_bits = ^core_pc[31:ADDR_W+2];

  // A loader beat is accepted only when the controller advertises ready
  assign xfer = ld_valid && ld_ready;

  // State register, clear/write pointers and load status bookkeeping
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state        <= CLEAR;
      clr_ptr      <= '0;
      wr_ptr       <= '0;
      load_count   <= '0;
      err_overflow <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        CLEAR: begin
          clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + 1'b1;
        end
        LOAD: begin
          if (xfer) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (ld_last) begin
              load_count <= wr_ptr + 1'b1;
              load_done  <= 1'b1;
            end else if (wr_ptr == LAST_PTR) begin
              err_overflow <= 1'b1;
              load_count   <= FULL_CNT;
              load_done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            clr_ptr      <= '0;
            wr_ptr       <= '0;
            load_count   <= '0;
            load_done    <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and memory/core port muxing keyed on the phase
  always_comb begin
    next_state   = state;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ld_ready     = 1'b0;
    core_stall   = 1'b1;
    instruction  = NOP_INSTR;
    err_misalign = 1'b0;
    // While reset is held every output stays at its idle value
    if (SYS_reset) begin
      case (state)
        CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = clr_ptr;
          if (clr_ptr == LAST_ADDR) next_state = LOAD;
        end
        LOAD: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_we    = 1'b1;
            mem_addr  = wr_ptr[ADDR_W-1:0];
            mem_wdata = ld_data;
            if (ld_last || (wr_ptr == LAST_PTR)) next_state = RUN;
          end
        end
        RUN: begin
          mem_addr     = core_pc[ADDR_W+1:2];
          instruction  = mem_rdata;
          core_stall   = 1'b0;
          err_misalign = |core_pc[1:0];
          if (load_start) next_state = CLEAR;
        end
        default: next_state = CLEAR;
      endcase
    end
  end

endmodule : imem_boot_ctrl
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_ctrl
// Purpose  : Directed self-checking bench for imem_boot_ctrl (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic [31:0]       core_pc;
  logic [31:0]       instruction;
  logic              core_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              err_overflow;
  logic              err_misalign;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [DEPTH];

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .SYS_clk      (clk),
    .SYS_reset    (rst_n),
    .load_start   (load_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .core_pc      (core_pc),
    .instruction  (instruction),
    .core_stall   (core_stall),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .load_done    (load_done),
    .load_count   (load_count),
    .err_overflow (err_overflow),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  // Memory array model: synchronous write, combinational read
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect DEPTH clear cycles starting now, then ld_ready in LOAD
  task automatic expect_clear(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check({tag, "_we"},    {31'd0, mem_we}, 32'd1);
      check({tag, "_addr"},  {28'd0, mem_addr}, i);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
      check({tag, "_stall"}, {31'd0, core_stall}, 32'd1);
      check({tag, "_instr"}, instruction, NOP);
      check({tag, "_rdy"},   {31'd0, ld_ready}, 32'd0);
      step();
    end
    @(negedge clk);
    check({tag, "_rdy_after"}, {31'd0, ld_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;

    rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; core_pc = 32'h6;
    step(); step();
    @(negedge clk);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_addr",  {28'd0, mem_addr}, 32'd0);
    check("rst_rdy",   {31'd0, ld_ready}, 32'd0);
    check("rst_stall", {31'd0, core_stall}, 32'd1);
    check("rst_instr", instruction, NOP);
    check("rst_mis",   {31'd0, err_misalign}, 32'd0);
    check("rst_done",  {31'd0, load_done}, 32'd0);
    check("rst_cnt",   {27'd0, load_count}, 32'd0);
    check("rst_ovf",   {31'd0, err_overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_clear("clr0");

    // Three-word program with one bubble before the second word
    step();
    ld_valid = 1'b1; ld_data = prog[0];
    @(negedge clk);
    check("w0_we", {31'd0, mem_we}, 32'd1);
    check("w0_addr", {28'd0, mem_addr}, 32'd0);
    check("w0_data", mem_wdata, prog[0]);
    step();
    ld_valid = 1'b0; ld_data = 32'hFFFF_FFFF; ld_last = 1'b1;
    @(negedge clk);
    check("bub_we", {31'd0, mem_we}, 32'd0);
    check("bub_rdy", {31'd0, ld_ready}, 32'd1);
    check("bub_done", {31'd0, load_done}, 32'd0);
    step();
    ld_valid = 1'b1; ld_data = prog[1]; ld_last = 1'b0;
    @(negedge clk);
    check("w1_addr", {28'd0, mem_addr}, 32'd1);
    check("w1_data", mem_wdata, prog[1]);
    step();
    ld_data = prog[2]; ld_last = 1'b1;
    @(negedge clk);
    check("w2_addr", {28'd0, mem_addr}, 32'd2);
    check("w2_stall", {31'd0, core_stall}, 32'd1);
    step();
    ld_valid = 1'b0; ld_last = 1'b0; core_pc = 32'h8;
    @(negedge clk);
    check("run_cnt",   {27'd0, load_count}, 32'd3);
    check("run_done",  {31'd0, load_done}, 32'd1);
    check("run_stall", {31'd0, core_stall}, 32'd0);
    check("run_rdy",   {31'd0, ld_ready}, 32'd0);
    check("run_we",    {31'd0, mem_we}, 32'd0);
    check("pc8_addr",  {28'd0, mem_addr}, 32'd2);
    check("pc8_instr", instruction, prog[2]);
    check("pc8_mis",   {31'd0, err_misalign}, 32'd0);
    check("mem3_clr",  mem[3], 32'd0);
    core_pc = 32'h6; #1;
    check("pc6_mis",   {31'd0, err_misalign}, 32'd1);
    check("pc6_instr", instruction, prog[1]);
    core_pc = 32'h40; #1;
    check("wrap_addr", {28'd0, mem_addr}, 32'd0);
    check("wrap_instr", instruction, prog[0]);

    // Reload request, then load_start during LOAD is ignored
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    @(negedge clk);
    check("rl_done", {31'd0, load_done}, 32'd0);
    check("rl_cnt",  {27'd0, load_count}, 32'd0);
    check("rl_ovf",  {31'd0, err_overflow}, 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i < DEPTH; i++) step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    @(negedge clk);
    check("ls_load_rdy", {31'd0, ld_ready}, 32'd1);
    check("ls_load_stall", {31'd0, core_stall}, 32'd1);

    // Overflow: 20 words without ld_last
    step();
    ld_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ld_data = 32'h100 + i;
      @(negedge clk);
      check("ovf_rdy", {31'd0, ld_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      check("ovf_we",  {31'd0, mem_we},  (i < DEPTH) ? 32'd1 : 32'd0);
      if (i < DEPTH) check("ovf_addr", {28'd0, mem_addr}, i);
      step();
    end
    ld_valid = 1'b0;
    @(negedge clk);
    check("ovf_flag", {31'd0, err_overflow}, 32'd1);
    check("ovf_cnt",  {27'd0, load_count}, 32'd16);
    check("ovf_done", {31'd0, load_done}, 32'd1);
    check("ovf_mem15", mem[15], 32'h10F);

    // Reset mid-LOAD after five words
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) step();
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_data = 32'h200 + i;
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_we",  {31'd0, mem_we}, 32'd0);
    check("mr_rdy", {31'd0, ld_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    check("mr_cnt", {27'd0, load_count}, 32'd0);
    check("mr_done", {31'd0, load_done}, 32'd0);
    @(posedge clk); #1;
    // The first clear cycle already elapsed above; re-check the full clear
    // by issuing another reset so the clear window is observed from word 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_clear("clr1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
`default_nettype wire

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Sequences the single-port instruction memory across boot and run phases.
- After reset it zero-clears every word, then loads a program from a valid/ready word stream, then releases the core.
- In the run phase it routes the core PC to the memory read address and returns the fetched instruction.
- Sits between the program-loader stream source, the instruction memory array and the core fetch stage.

Parameters:
- DEPTH, 1024, number of 32-bit words in the instruction memory.
- ADDR_W, 10, memory word-address width; must equal clog2(DEPTH).

Ports:
- SYS_clk  in  1  system clock; all state updates on rising edge.
- SYS_reset  in  1  synchronous, active-low reset.
- load_start  in  1  request a reload; sampled only in RUN.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  marks the final word of the program; qualified by ld_valid.
- ld_ready  out  1  controller accepts a loader word.
- core_pc  in  32  core byte PC; word index is core_pc[ADDR_W+1:2].
- instruction  out  32  instruction delivered to the core.
- core_stall  out  1  core must hold its PC.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address (shared by reads and writes).
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data at mem_addr.
- load_done  out  1  program loaded and core running.
- load_count  out  ADDR_W+1  number of words written by the last load.
- err_overflow  out  1  program exceeded DEPTH words.
- err_misalign  out  1  core_pc[1:0] != 0 while in RUN.

Behaviour:
- Reset: reset is synchronous and active-low, one clock. While SYS_reset=0, on every edge:
  - state <- CLEAR, clr_ptr <- 0, wr_ptr <- 0.
  - load_count <- 0, err_overflow <- 0, load_done <- 0.
- Reset asserted in any state, including mid-CLEAR or mid-LOAD, aborts that state immediately. No write from the reset cycle is performed (mem_we=0 while SYS_reset=0).
- Output values while in reset: mem_we=0, mem_addr=0, mem_wdata=0, ld_ready=0, core_stall=1, instruction=NOP (0x00000013), err_misalign=0.
- CLEAR state:
  - mem_we=1, mem_addr=clr_ptr, mem_wdata=0.
  - clr_ptr increments every cycle.
  - When clr_ptr==DEPTH-1, that word is written and the next state is LOAD.
  - Takes exactly DEPTH cycles.
- LOAD state:
  - ld_ready=1.
  - A transfer occurs when ld_valid && ld_ready. On a transfer: mem_we=1, mem_addr=wr_ptr[ADDR_W-1:0], mem_wdata=ld_data, and wr_ptr increments.
  - No transfer means mem_we=0.
  - A transfer with ld_last=1 sets load_count <- wr_ptr+1 and load_done <- 1, and moves to RUN.
  - A transfer without ld_last at wr_ptr==DEPTH-1 writes that word, then sets err_overflow <- 1, load_count <- DEPTH and load_done <- 1, and moves to RUN.
  - Surplus stream words after an overflow are never accepted (ld_ready=0 in RUN).
- RUN state:
  - mem_we=0, mem_addr=core_pc[ADDR_W+1:2], instruction=mem_rdata, core_stall=0.
  - err_misalign = |core_pc[1:0]; combinational, no state change.
  - PC beyond DEPTH wraps via truncation.
  - load_start=1 moves to CLEAR next cycle; counters, load_done and err_overflow clear on that transition.
- In every state except RUN: core_stall=1 and instruction=NOP. Fetch latency in RUN is 0 cycles (combinational read).
- load_start is ignored outside RUN. ld_last is ignored when ld_valid=0.
- First possible loader transfer is DEPTH cycles after reset release. core_stall falls in the cycle after the last-word transfer.

Decomposition:
- Shared package imem_boot_pkg: state typedef {CLEAR, LOAD, RUN}, NOP_INSTR=32'h00000013, DEFAULT_DEPTH=1024.
- Single module; no sub-module. Address/data muxing is a small combinational block keyed on state.

Test Plan:
- Release reset with DEPTH=16 -> 16 consecutive cycles with mem_we=1, mem_addr 0..15, mem_wdata=0; ld_ready rises on cycle 17; core_stall=1 and instruction=0x00000013 throughout.
- Stream 3 words 0x00500093, 0x00A00113, 0x002081B3 with ld_last on the third, inserting one ld_valid=0 bubble -> writes at addresses 0,1,2 only; no write in the bubble cycle; load_count=3, load_done=1; core_stall=0 next cycle.
- In RUN, core_pc=0x8 with mem_rdata=0x002081B3 -> mem_addr=2, instruction=0x002081B3 same cycle; core_pc=0x6 -> err_misalign=1.
- DEPTH=16, stream 20 words with no ld_last -> 16 writes, err_overflow=1, load_count=16, ld_ready=0 from the 17th word onward.
- SYS_reset=0 for one cycle mid-LOAD after 5 words -> mem_we=0 that cycle; state returns to CLEAR; load_count=0; a full 16-cycle clear is observed.
- load_start=1 in RUN -> next cycle CLEAR with load_done=0 and err_overflow=0; load_start pulsed during LOAD has no effect.
